// File: rtl/pkg_astrogenius.sv
// Shared definitions of the astrogenius game datapath:
// control-unit state codes and shot-table constants.
package pkg_astrogenius;

    localparam int N_TIROS_PAD = 4;
    localparam int W_DIR_PAD   = 3;
    localparam int W_POS_PAD   = 5;

    localparam logic [4:0] POS_X_INI_PAD = 5'd16;
    localparam logic [4:0] POS_Y_INI_PAD = 5'd16;

    localparam logic [3:0] DB_ERRO = 4'hF;

    typedef enum logic [3:0] {
        ESPERA = 4'd0,
        BUSCA  = 4'd1,
        GRAVA  = 4'd2,
        FIM    = 4'd3
    } estado_t;

endpackage

// File: rtl/tabela_ocupacao_tiros.sv
// Shot-slot occupancy bitmap; a set and a clear
// of the same slot at the same edge leaves it set.
module tabela_ocupacao_tiros #(
    parameter int N_TIROS = 4,
    parameter int W_IDX   = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               limpa,
    input  logic               set,
    input  logic [W_IDX-1:0]   set_idx,
    input  logic               clr,
    input  logic [W_IDX-1:0]   clr_idx,
    output logic [N_TIROS-1:0] ocupados
);

    localparam logic [N_TIROS-1:0] UM = N_TIROS'(1);

    logic [N_TIROS-1:0] set_mask;
    logic [N_TIROS-1:0] clr_mask;

    assign set_mask = set ? (UM << set_idx) : '0;
    assign clr_mask = clr ? (UM << clr_idx) : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ocupados <= '0;
        end else if (limpa) begin
            ocupados <= '0;
        end else begin
            ocupados <= (ocupados & ~clr_mask) | set_mask;
        end
    end

endmodule

// File: rtl/uc_registra_tiros.sv
// Shot-registration control: finds the lowest free slot,
// writes the new shot into the table and reports back.
module uc_registra_tiros
    import pkg_astrogenius::*;
#(
    parameter int         N_TIROS       = N_TIROS_PAD,
    parameter int         W_IDX         = $clog2(N_TIROS),
    parameter int         W_DIR         = W_DIR_PAD,
    parameter int         W_POS         = W_POS_PAD,
    parameter logic [W_POS-1:0] POS_X_INICIAL = POS_X_INI_PAD,
    parameter logic [W_POS-1:0] POS_Y_INICIAL = POS_Y_INI_PAD
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     limpa,
    input  logic                     iniciar,
    input  logic [W_DIR-1:0]         direcao,
    input  logic                     libera_tiro,
    input  logic [W_IDX-1:0]         libera_idx,
    output logic                     we_tiro,
    output logic [W_IDX-1:0]         endereco_tiro,
    output logic [W_DIR+2*W_POS-1:0] dado_tiro,
    output logic                     fim_registra_tiros,
    output logic                     tiro_descartado,
    output logic [N_TIROS-1:0]       ocupados,
    output logic [3:0]               db_estado
);

    localparam logic [W_IDX-1:0] IDX_MAX = W_IDX'(N_TIROS - 1);

    estado_t                  estado, prox;
    logic [W_IDX-1:0]         idx, idx_prox;
    logic [W_DIR-1:0]         dir_q, dir_prox;
    logic                     desc_q, desc_prox;
    logic                     carrega;
    logic [W_IDX-1:0]         end_q;
    logic [W_DIR+2*W_POS-1:0] dado_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado <= ESPERA;
            idx    <= '0;
            dir_q  <= '0;
            desc_q <= 1'b0;
            end_q  <= '0;
            dado_q <= '0;
        end else if (limpa) begin
            estado <= ESPERA;
            idx    <= '0;
            dir_q  <= '0;
            desc_q <= 1'b0;
            end_q  <= '0;
            dado_q <= '0;
        end else begin
            estado <= prox;
            idx    <= idx_prox;
            dir_q  <= dir_prox;
            desc_q <= desc_prox;
            // Write port is loaded on entry to GRAVA and then held
            if (carrega) begin
                end_q  <= idx;
                dado_q <= {dir_q, POS_Y_INICIAL, POS_X_INICIAL};
            end
        end
    end

    always_comb begin
        prox      = estado;
        idx_prox  = idx;
        dir_prox  = dir_q;
        desc_prox = desc_q;
        carrega   = 1'b0;
        case (estado)
            ESPERA: begin
                if (iniciar) begin
                    dir_prox  = direcao;
                    idx_prox  = '0;
                    desc_prox = 1'b0;
                    prox      = BUSCA;
                end
            end
            BUSCA: begin
                if (!ocupados[idx]) begin
                    carrega = 1'b1;
                    prox    = GRAVA;
                end else if (idx == IDX_MAX) begin
                    desc_prox = 1'b1;
                    prox      = FIM;
                end else begin
                    idx_prox = idx + 1'b1;
                end
            end
            GRAVA:   prox = FIM;
            FIM:     prox = ESPERA;
            default: prox = ESPERA;
        endcase
    end

    assign we_tiro            = (estado == GRAVA);
    assign fim_registra_tiros = (estado == FIM);
    assign tiro_descartado    = (estado == FIM) && desc_q;
    assign endereco_tiro      = end_q;
    assign dado_tiro          = dado_q;

    always_comb begin
        db_estado = DB_ERRO;
        case (estado)
            ESPERA:  db_estado = 4'd0;
            BUSCA:   db_estado = 4'd1;
            GRAVA:   db_estado = 4'd2;
            FIM:     db_estado = 4'd3;
            default: db_estado = DB_ERRO;
        endcase
    end

    tabela_ocupacao_tiros #(
        .N_TIROS (N_TIROS),
        .W_IDX   (W_IDX)
    ) u_tabela (
        .clock    (clock),
        .reset_n  (reset_n),
        .limpa    (limpa),
        .set      (estado == GRAVA),
        .set_idx  (idx),
        .clr      (libera_tiro),
        .clr_idx  (libera_idx),
        .ocupados (ocupados)
    );

endmodule

// File: doc/uc_registra_tiros.md
Name: uc_registra_tiros

Overview:
- Shot-registration control stage that sits directly downstream of the main game control unit.
- Started by the main unit's inicia_registra_tiros pulse; returns fim_registra_tiros to it.
- Allocates a free slot in the shot table, writes the new shot's initial position and direction through a single write port, and keeps the slot-occupancy bitmap.
- The shot movement/collision stage frees slots through a release port.

Parameters:
N_TIROS, 4, number of shot slots (2..16)
W_IDX, 2, slot index width, equals clog2(N_TIROS)
W_DIR, 3, shot direction code width (8 directions)
W_POS, 5, width of each position coordinate
POS_X_INICIAL, 5'd16, x coordinate written for every new shot (ship centre)
POS_Y_INICIAL, 5'd16, y coordinate written for every new shot

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
limpa  in  1  synchronous clear, driven by the main unit's reset_maquinas
iniciar  in  1  start request (inicia_registra_tiros), sampled only in ESPERA
direcao  in  W_DIR  direction of the new shot, captured with iniciar
libera_tiro  in  1  release strobe from the movement/collision stage
libera_idx  in  W_IDX  slot to release
we_tiro  out  1  shot-table write enable, one cycle
endereco_tiro  out  W_IDX  shot-table write address
dado_tiro  out  W_DIR+2*W_POS  write data, {direcao, POS_Y_INICIAL, POS_X_INICIAL}
fim_registra_tiros  out  1  one-cycle done pulse to the main unit
tiro_descartado  out  1  high together with fim when no slot was free
ocupados  out  N_TIROS  slot valid bitmap (registered)
db_estado  out  4  debug state code

Behaviour:
- Everything is registered in the clock domain. Moore outputs are decoded from the state and registered data.
- Reset (reset_n=0, any time, including mid-search): state=ESPERA; ocupados=0; index counter=0; captured direction=0; descartado flag=0.
- While reset_n=0: all outputs are 0; dado_tiro=0.
- limpa=1 gives the same effect as reset at the next edge and has priority over every other input.
- States and codes:
  - ESPERA(0): if iniciar, capture direcao, set idx=0, clear descartado flag, go to BUSCA. Otherwise stay.
  - BUSCA(1): test ocupados[idx] (registered value, no bypass).
    - Slot free: go to GRAVA.
    - Slot occupied and idx==N_TIROS-1: set descartado flag, go to FIM.
    - Otherwise: idx++ and stay in BUSCA.
  - GRAVA(2): we_tiro=1, endereco_tiro=idx, dado_tiro valid. Set ocupados[idx] at the edge leaving the state. Go to FIM.
  - FIM(3): fim_registra_tiros=1; tiro_descartado=descartado flag. Go to ESPERA.
  - Unused codes: go to ESPERA; db_estado=4'hF.
- endereco_tiro and dado_tiro hold their last values outside GRAVA; the consumer uses them only when we_tiro=1.
- Latency, iniciar sampled at edge k:
  - Slot j free, all lower slots occupied: GRAVA during cycle k+2+j, fim during cycle k+3+j.
  - Table full: fim plus descartado during cycle k+1+N_TIROS; no write occurs.
- iniciar outside ESPERA is ignored; no queuing.
- Holding iniciar high in FIM's following ESPERA starts a new registration. The main unit pulses it for one cycle only.
- Release: libera_tiro clears ocupados[libera_idx] at the next edge, in any state.
- Release and set of the same slot at the same edge: the set wins.
- Release of a different slot at the same edge: both take effect.
- A release of slot idx during BUSCA is seen on the next test only. The current test uses the old value.
- Releasing an already-free slot has no effect.
- Slots are allocated lowest free index first.

Decomposition:
- Shared package (pkg_astrogenius): state codes ESPERA/BUSCA/GRAVA/FIM, the debug error code 4'hF, N_TIROS/W_DIR/W_POS defaults, and the initial-position constants shared with the movement stage.
- One natural sub-module, tabela_ocupacao_tiros: the valid bitmap with set(idx)/clear(idx) ports, set-wins priority, and synchronous clear.
- The FSM and the index counter stay in uc_registra_tiros.

Test Plan:
- Reset, then iniciar=1 for one cycle, direcao=3'd5, table empty → we_tiro at cycle k+2 with endereco=0 and dado={3'd5,5'd16,5'd16}; fim at k+3; tiro_descartado=0; ocupados=4'b0001.
- ocupados=4'b0111 preloaded by three registrations, then iniciar → endereco=3, fim at k+6, ocupados=4'b1111.
- Table full (4'b1111), then iniciar → no we_tiro; fim and tiro_descartado both high at cycle k+5; ocupados unchanged.
- Full table, libera_tiro with idx=2 in the same cycle as iniciar → search finds slot 2, writes endereco=2, ocupados=4'b1111 afterwards.
- Release of slot 1 at the same edge GRAVA sets slot 1 → ocupados[1]=1 (set wins); a second iniciar during BUSCA is ignored (exactly one fim).
- reset_n pulsed low mid-BUSCA, and separately limpa=1 in GRAVA → next cycle state=ESPERA, ocupados=0, no fim pulse, no write committed.
